// File: rtl/udp_depacketizer_pkg.sv
// Shared Ethernet/IPv4/UDP constants and parser state encoding for the
// UDP packetizer/depacketizer pair.
package udp_depacketizer_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

  // Header word indices on the shift16 MAC stream (word 0 carries the pad).
  localparam logic [3:0] W_DMAC_HI  = 4'd0;
  localparam logic [3:0] W_DMAC_LO  = 4'd1;
  localparam logic [3:0] W_ETYPE    = 4'd3;
  localparam logic [3:0] W_VER_LEN  = 4'd4;
  localparam logic [3:0] W_FRAG     = 4'd5;
  localparam logic [3:0] W_PROTO    = 4'd6;
  localparam logic [3:0] W_SRC_IP   = 4'd7;
  localparam logic [3:0] W_DST_IP   = 4'd8;
  localparam logic [3:0] W_PORTS    = 4'd9;
  localparam logic [3:0] W_UDP_LEN  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP,
    ST_DROP_SILENT
  } state_e;

endpackage

// File: rtl/udp_depacketizer_ip_csum16.sv
// Incremental ones-complement adder taking two halfwords per add; sum is the
// folded total including the current din, acc holds the running value.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [31:0] din,
  output logic [15:0] sum
);

  logic [15:0] acc_q, acc_d;
  logic [15:0] base;
  logic [17:0] raw;
  logic [16:0] fold1;

  // Two end-around folds are enough: three 16-bit addends peak at 0x2FFFD.
  always_comb begin
    base  = clr ? 16'h0000 : acc_q;
    raw   = {2'b00, base} + {2'b00, din[31:16]} + {2'b00, din[15:0]};
    fold1 = {1'b0, raw[15:0]} + {15'd0, raw[17:16]};
    sum   = fold1[15:0] + {15'd0, fold1[16]};
    if (add) begin
      acc_d = sum;
    end else begin
      acc_d = base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 16'h0000;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/udp_depacketizer.sv
// Ethernet/IPv4/UDP receive filter delivering the UDP payload as a word stream.
// Optional IPv4 header checksum verification: define DEPKT_IPCSUM_EN.
module udp_depacketizer
  import udp_depacketizer_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h021234566790,
  parameter logic [31:0] LOCAL_IP   = {8'd10, 8'd0, 8'd0, 8'd2},
  parameter logic [15:0] LOCAL_PORT = 16'd32179,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ff_rx_data,
  input  logic             ff_rx_sop,
  input  logic             ff_rx_eop,
  input  logic [1:0]       ff_rx_mod,
  input  logic             ff_rx_dval,
  input  logic             ff_rx_err,
  output logic             ff_rx_rdy,
  output logic [31:0]      pl_data,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic             pl_sop,
  output logic             pl_eop,
  output logic [1:0]       pl_mod,
  output logic             pl_err,
  output logic [CNT_W-1:0] rx_good_cnt,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      rem_q, rem_d;
  logic             mac_local_q, mac_local_d;
  logic             mac_bcast_q, mac_bcast_d;
  logic             first_q, first_d;
  logic [31:0]      pl_data_q, pl_data_d;
  logic             pl_valid_q, pl_valid_d;
  logic             pl_sop_q, pl_sop_d;
  logic             pl_eop_q, pl_eop_d;
  logic [1:0]       pl_mod_q, pl_mod_d;
  logic             pl_err_q, pl_err_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             good_inc, drop_inc;
  logic             out_free, accept, hdr_ok, csum_ok;
  logic [2:0]       mod_tail;
  logic [15:0]      udp_rem;

  // A sop arriving mid-payload stalls the MAC one cycle while the flush word goes out.
  assign out_free  = ~pl_valid_q | pl_ready;
  assign ff_rx_rdy = (state_q == ST_PAYLOAD) ? (out_free & ~(ff_rx_dval & ff_rx_sop)) : 1'b1;
  assign accept    = ff_rx_dval & ff_rx_rdy;
  assign udp_rem   = ff_rx_data[31:16] - UDP_HDR_BYTES;
  assign mod_tail  = 3'd4 - rem_q[2:0];

`ifdef DEPKT_IPCSUM_EN
  logic [15:0] csum_sum;
  logic        csum_add;
  assign csum_add = accept & ~ff_rx_sop & (state_q == ST_HDR) &
                    (idx_q >= W_VER_LEN) & (idx_q <= W_DST_IP);
  ip_csum16 u_csum (
    .clk (clk),
    .rst (rst),
    .clr (accept & ff_rx_sop),
    .add (csum_add),
    .din (ff_rx_data),
    .sum (csum_sum)
  );
  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    case (idx_q)
      W_DMAC_LO: hdr_ok = (mac_local_q && ff_rx_data == LOCAL_MAC[31:0]) ||
                          (mac_bcast_q && ff_rx_data == 32'hFFFF_FFFF);
      W_ETYPE:   hdr_ok = (ff_rx_data[15:0] == ETHERTYPE_IPV4);
      W_VER_LEN: hdr_ok = (ff_rx_data[31:24] == IPV4_VER_IHL);
      W_FRAG:    hdr_ok = (ff_rx_data[13:0] == 14'd0);
      W_PROTO:   hdr_ok = (ff_rx_data[23:16] == IP_PROTO_UDP);
      W_DST_IP:  hdr_ok = (ff_rx_data == LOCAL_IP) && csum_ok;
      W_PORTS:   hdr_ok = (ff_rx_data[15:0] == LOCAL_PORT);
      W_UDP_LEN: hdr_ok = (ff_rx_data[31:16] >= UDP_HDR_BYTES);
      default:   hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    mac_local_d = mac_local_q;
    mac_bcast_d = mac_bcast_q;
    first_d     = first_q;
    pl_data_d   = pl_data_q;
    pl_valid_d  = pl_valid_q & ~pl_ready;
    pl_sop_d    = pl_sop_q;
    pl_eop_d    = pl_eop_q;
    pl_mod_d    = pl_mod_q;
    pl_err_d    = pl_err_q;
    good_inc    = 1'b0;
    drop_inc    = 1'b0;

    if (state_q == ST_PAYLOAD && ff_rx_dval && ff_rx_sop && out_free) begin
      pl_valid_d = 1'b1;
      pl_data_d  = 32'h0000_0000;
      pl_sop_d   = 1'b0;
      pl_eop_d   = 1'b1;
      pl_err_d   = 1'b1;
      pl_mod_d   = 2'd0;
      drop_inc   = 1'b1;
      state_d    = ST_IDLE;
    end else if (accept && ff_rx_sop) begin
      // A sop outside IDLE aborts the frame in progress; sop+eop is a runt.
      drop_inc    = (state_q != ST_IDLE) | ff_rx_eop;
      mac_local_d = (ff_rx_data[15:0] == LOCAL_MAC[47:32]);
      mac_bcast_d = (ff_rx_data[15:0] == 16'hFFFF);
      idx_d       = W_DMAC_LO;
      state_d     = ff_rx_eop ? ST_IDLE : ST_HDR;
    end else if (accept) begin
      case (state_q)
        ST_HDR: begin
          if (ff_rx_eop) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else if (!hdr_ok) begin
            state_d = ST_DROP;
          end else if (idx_q == W_UDP_LEN) begin
            rem_d   = udp_rem;
            first_d = 1'b1;
            state_d = (udp_rem == 16'd0) ? ST_DROP_SILENT : ST_PAYLOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = ff_rx_data;
          pl_sop_d   = first_q;
          first_d    = 1'b0;
          pl_eop_d   = 1'b0;
          pl_err_d   = 1'b0;
          pl_mod_d   = 2'd0;
          if (rem_q <= 16'd4) begin
            pl_eop_d = 1'b1;
            pl_mod_d = mod_tail[1:0];
            if (ff_rx_eop) begin
              pl_err_d = ff_rx_err;
              drop_inc = ff_rx_err;
              good_inc = ~ff_rx_err;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_DROP_SILENT;
            end
          end else begin
            rem_d = rem_q - 16'd4;
            if (ff_rx_eop) begin
              pl_eop_d = 1'b1;
              pl_err_d = 1'b1;
              pl_mod_d = ff_rx_mod;
              drop_inc = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_DROP: begin
          if (ff_rx_eop) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_DROP_SILENT: begin
          // Payload already delivered; the trailing eop decides good vs dropped.
          if (ff_rx_eop) begin
            good_inc = ~ff_rx_err;
            drop_inc = ff_rx_err;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DROP_SILENT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    good_d = good_inc ? good_q + CNT_W'(1) : good_q;
    drop_d = drop_inc ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= W_DMAC_HI;
      rem_q       <= 16'd0;
      mac_local_q <= 1'b0;
      mac_bcast_q <= 1'b0;
      first_q     <= 1'b0;
      pl_data_q   <= 32'h0000_0000;
      pl_valid_q  <= 1'b0;
      pl_sop_q    <= 1'b0;
      pl_eop_q    <= 1'b0;
      pl_mod_q    <= 2'd0;
      pl_err_q    <= 1'b0;
      good_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      mac_local_q <= mac_local_d;
      mac_bcast_q <= mac_bcast_d;
      first_q     <= first_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_sop_q    <= pl_sop_d;
      pl_eop_q    <= pl_eop_d;
      pl_mod_q    <= pl_mod_d;
      pl_err_q    <= pl_err_d;
      good_q      <= good_d;
      drop_q      <= drop_d;
    end
  end

  assign pl_data     = pl_data_q;
  assign pl_valid    = pl_valid_q;
  assign pl_sop      = pl_sop_q;
  assign pl_eop      = pl_eop_q;
  assign pl_mod      = pl_mod_q;
  assign pl_err      = pl_err_q;
  assign rx_good_cnt = good_q;
  assign rx_drop_cnt = drop_q;

endmodule

// File: tb/tb_udp_depacketizer.sv
// Directed, table-driven bench for udp_depacketizer: frames are built byte by
// byte, streamed through the MAC-side handshake and the payload is scoreboarded.
module tb_udp_depacketizer;

  logic        clk;
  logic        rst;
  logic [31:0] ff_rx_data;
  logic        ff_rx_sop, ff_rx_eop, ff_rx_dval, ff_rx_err;
  logic [1:0]  ff_rx_mod;
  logic        ff_rx_rdy;
  logic [31:0] pl_data;
  logic        pl_valid, pl_ready, pl_sop, pl_eop, pl_err;
  logic [1:0]  pl_mod;
  logic [15:0] rx_good_cnt, rx_drop_cnt;

  udp_depacketizer dut (
    .clk(clk), .rst(rst),
    .ff_rx_data(ff_rx_data), .ff_rx_sop(ff_rx_sop), .ff_rx_eop(ff_rx_eop),
    .ff_rx_mod(ff_rx_mod), .ff_rx_dval(ff_rx_dval), .ff_rx_err(ff_rx_err),
    .ff_rx_rdy(ff_rx_rdy),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pl_sop(pl_sop), .pl_eop(pl_eop), .pl_mod(pl_mod), .pl_err(pl_err),
    .rx_good_cnt(rx_good_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [15:0] frag;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [15:0] udp_len;
    int          len_ovr;
    logic        err;
    logic        csum_bad;
    int          exp_words;
    logic [1:0]  exp_mod;
    logic        exp_err;
    int          exp_good;
    int          exp_drop;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  m;
    logic        er;
  } beat_t;

  localparam logic [47:0] M  = 48'h021234566790;
  localparam logic [15:0] ET = 16'h0800;
  localparam logic [15:0] FR = 16'h4000;
  localparam logic [31:0] IP = 32'h0a000002;
  localparam logic [15:0] PT = 16'd32179;
  localparam int          NV = 14;

  vec_t        vecs [NV];
  beat_t       out_q [$];
  logic [7:0]  fb [0:511];
  logic [31:0] fw [0:127];
  int          fw_n;
  logic [1:0]  fw_mod;
  int          bp;
  logic [7:0]  seed = 8'h11;
  int          n_pass = 0;
  int          n_total = 0;
  int          exp_good = 0;
  int          exp_drop = 0;

  always @(negedge clk) begin
    if (!rst && pl_valid && pl_ready) out_q.push_back({pl_data, pl_sop, pl_eop, pl_mod, pl_err});
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] frag,
                              input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] udp_len,
                              input int len_ovr, input logic err, input logic csum_bad, input int ew,
                              input logic [1:0] em, input logic ee, input int eg, input int ed);
    vec_t v;
    v.dmac = dmac; v.etype = etype; v.frag = frag; v.dip = dip; v.dport = dport;
    v.udp_len = udp_len; v.len_ovr = len_ovr; v.err = err; v.csum_bad = csum_bad;
    v.exp_words = ew; v.exp_mod = em; v.exp_err = ee; v.exp_good = eg; v.exp_drop = ed;
    return v;
  endfunction

  task automatic put8(input logic [7:0] b);
    fb[bp] = b;
    bp++;
  endtask

  task automatic put16(input logic [15:0] h);
    put8(h[15:8]);
    put8(h[7:0]);
  endtask

  task automatic build_frame(input vec_t v);
    logic [15:0] h [10];
    logic [31:0] s;
    logic [15:0] ck;
    logic [47:0] smac;
    int pay, eth, tot;
    smac = 48'h02aabbccddee;
    for (int i = 0; i < 512; i++) fb[i] = 8'h00;
    pay = (v.udp_len >= 16'd8) ? int'(v.udp_len) - 8 : 0;
    h[0] = 16'h4500; h[1] = 16'd20 + v.udp_len; h[2] = 16'h1234; h[3] = v.frag;
    h[4] = 16'h4011; h[5] = 16'h0000; h[6] = 16'h0a00; h[7] = 16'h0001;
    h[8] = v.dip[31:16]; h[9] = v.dip[15:0];
    s = 32'd0;
    for (int i = 0; i < 10; i++) s = s + {16'd0, h[i]};
    s = (s & 32'h0000FFFF) + (s >> 16);
    s = (s & 32'h0000FFFF) + (s >> 16);
    ck = ~s[15:0];
    if (v.csum_bad) ck = ck ^ 16'h0001;
    h[5] = ck;
    bp = 2;
    for (int i = 0; i < 6; i++) put8(v.dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) put8(smac[47-8*i -: 8]);
    put16(v.etype);
    for (int i = 0; i < 10; i++) put16(h[i]);
    put16(16'd5000);
    put16(v.dport);
    put16(v.udp_len);
    put16(16'h0000);
    for (int i = 0; i < pay; i++) put8(seed + 8'(i * 13));
    seed = seed + 8'h1D;
    eth = 42 + pay;
    if (eth < 60) eth = 60;
    if (v.len_ovr > 0) eth = v.len_ovr;
    tot = eth + 2;
    for (int i = tot; i < 512; i++) fb[i] = 8'h00;
    fw_n = (tot + 3) / 4;
    fw_mod = 2'((4 - tot % 4) % 4);
    for (int k = 0; k < fw_n; k++) fw[k] = {fb[4*k], fb[4*k+1], fb[4*k+2], fb[4*k+3]};
  endtask

  task automatic drive_word(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] m, input logic er);
    int waited;
    ff_rx_data = d; ff_rx_sop = s; ff_rx_eop = e; ff_rx_mod = m; ff_rx_err = er;
    ff_rx_dval = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!ff_rx_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ff_rx_rdy) begin
      n_total++;
      $display("FAIL rx_rdy_timeout: ff_rx_rdy stayed 0 for %0d cycles, want 1", waited);
    end
    @(posedge clk);
    #1;
    ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0; ff_rx_mod = 2'd0;
  endtask

  task automatic send_frame(input int first, input int last_excl, input logic with_eop, input logic err);
    logic last;
    for (int k = first; k < last_excl; k++) begin
      last = with_eop && (k == fw_n - 1);
      drive_word(fw[k], k == 0, last, last ? fw_mod : 2'd0, last & err);
    end
  endtask

  task automatic check_payload(input string tag, input int ew, input logic [1:0] em, input logic ee);
    beat_t b;
    check({tag, "_words"}, out_q.size(), ew);
    for (int k = 0; k < out_q.size() && k < ew; k++) begin
      b = out_q[k];
      check($sformatf("%s_data%0d", tag, k), b.d, fw[11 + k]);
      check($sformatf("%s_sop%0d", tag, k), b.s, k == 0);
      check($sformatf("%s_eop%0d", tag, k), b.e, k == ew - 1);
      if (k == ew - 1) begin
        check({tag, "_mod"}, b.m, em);
        check({tag, "_err"}, b.er, ee);
      end else begin
        check($sformatf("%s_err%0d", tag, k), b.er, 1'b0);
      end
    end
    out_q.delete();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_good_cnt"}, rx_good_cnt, exp_good);
    check({tag, "_drop_cnt"}, rx_drop_cnt, exp_drop);
  endtask

  initial begin
    beat_t       b;
    logic [31:0] a11, a12;

    vecs[0]  = mk(M, ET, FR, IP, PT, 16'd24, 0, 1'b0, 1'b0, 4, 2'd0, 1'b0, 1, 0);
    vecs[1]  = mk(M, ET, FR, IP, PT, 16'd13, 0, 1'b0, 1'b0, 2, 2'd3, 1'b0, 1, 0);
    vecs[2]  = mk(M, ET, FR, IP, 16'd1234, 16'd24, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[3]  = mk(M, ET, FR, 32'h0a000009, PT, 16'd24, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[4]  = mk(M, 16'h0806, FR, IP, PT, 16'd24, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[5]  = mk(M, ET, FR, IP, PT, 16'd72, 0, 1'b1, 1'b0, 16, 2'd0, 1'b1, 0, 1);
    vecs[6]  = mk(48'hFFFFFFFFFFFF, ET, FR, IP, PT, 16'd8, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 1, 0);
    vecs[7]  = mk(48'h021234566791, ET, FR, IP, PT, 16'd24, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[8]  = mk(M, ET, 16'h2000, IP, PT, 16'd24, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[9]  = mk(M, ET, FR, IP, PT, 16'd7, 0, 1'b0, 1'b0, 0, 2'd0, 1'b0, 0, 1);
    vecs[10] = mk(M, ET, FR, IP, PT, 16'd24, 51, 1'b0, 1'b0, 3, 2'd3, 1'b1, 0, 1);
    vecs[11] = mk(M, ET, FR, IP, PT, 16'd13, 0, 1'b1, 1'b0, 2, 2'd3, 1'b0, 0, 1);
    vecs[12] = mk(M, ET, FR, IP, PT, 16'd19, 53, 1'b0, 1'b0, 3, 2'd1, 1'b0, 1, 0);
`ifdef DEPKT_IPCSUM_EN
    vecs[13] = mk(M, ET, FR, IP, PT, 16'd24, 0, 1'b0, 1'b1, 0, 2'd0, 1'b0, 0, 1);
`else
    vecs[13] = mk(M, ET, FR, IP, PT, 16'd24, 0, 1'b0, 1'b1, 4, 2'd0, 1'b0, 1, 0);
`endif

    ff_rx_data = 32'd0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_mod = 2'd0;
    ff_rx_dval = 1'b0; ff_rx_err = 1'b0; pl_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pl_valid", pl_valid, 1'b0);
    check("rst_pl_sop", pl_sop, 1'b0);
    check("rst_pl_eop", pl_eop, 1'b0);
    check("rst_pl_err", pl_err, 1'b0);
    check("rst_pl_mod", pl_mod, 2'd0);
    check("rst_pl_data", pl_data, 32'd0);
    check("rst_rdy", ff_rx_rdy, 1'b1);
    check_counts("rst");
    rst = 1'b0;

    // Reset in the middle of a payload: frame vanishes, nothing counted.
    build_frame(vecs[0]);
    send_frame(0, 13, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_pl_valid", pl_valid, 1'b0);
    check_counts("midrst");
    out_q.delete();

    for (int i = 0; i < NV; i++) begin
      build_frame(vecs[i]);
      send_frame(0, fw_n, 1'b1, vecs[i].err);
      repeat (4) @(posedge clk);
      #1;
      exp_good += vecs[i].exp_good;
      exp_drop += vecs[i].exp_drop;
      check_payload($sformatf("v%0d", i), vecs[i].exp_words, vecs[i].exp_mod, vecs[i].exp_err);
      check_counts($sformatf("v%0d", i));
    end

    // Downstream stalls 10 cycles mid-payload.
    build_frame(vecs[0]);
    build_frame(mk(M, ET, FR, IP, PT, 16'd72, 0, 1'b0, 1'b0, 16, 2'd0, 1'b0, 1, 0));
    fork
      send_frame(0, fw_n, 1'b1, 1'b0);
      begin
        repeat (16) @(posedge clk);
        #1;
        pl_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_rdy_low", ff_rx_rdy, 1'b0);
        check("bp_valid_held", pl_valid, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        pl_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    exp_good += 1;
    check_payload("bp", 16, 2'd0, 1'b0);
    check_counts("bp");

    // New sop while a payload is in flight: flush word, then the new frame.
    build_frame(vecs[0]);
    a11 = fw[11];
    a12 = fw[12];
    send_frame(0, 13, 1'b0, 1'b0);
    build_frame(vecs[1]);
    send_frame(0, fw_n, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    exp_good += 1;
    exp_drop += 1;
    check("abort_words", out_q.size(), 5);
    if (out_q.size() == 5) begin
      b = out_q[0];
      check("abort_a0_data", b.d, a11);
      check("abort_a0_sop", b.s, 1'b1);
      b = out_q[1];
      check("abort_a1_data", b.d, a12);
      check("abort_a1_eop", b.e, 1'b0);
      b = out_q[2];
      check("abort_flush", {b.d, b.s, b.e, b.m, b.er}, {32'd0, 1'b0, 1'b1, 2'd0, 1'b1});
      b = out_q[3];
      check("abort_b0", {b.d, b.s, b.e}, {fw[11], 1'b1, 1'b0});
      b = out_q[4];
      check("abort_b1", {b.d, b.s, b.e, b.m, b.er}, {fw[12], 1'b0, 1'b1, 2'd3, 1'b0});
    end
    out_q.delete();
    check_counts("abort");

    // One-word frame carrying both sop and eop.
    drive_word(32'h0000_0212, 1'b1, 1'b1, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    exp_drop += 1;
    check("runt_words", out_q.size(), 0);
    check_counts("runt");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
